// File: rtl/nios2_ls_onchip_memory_fill_engine.sv
// Fill / checksum engine sitting in front of the on-chip RAM's second port.
// A small control slave programs a word range, then the engine fills it or sums it back.
module nios2_ls_onchip_memory_fill_engine #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 14
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            ctl_address,
    input  logic                  ctl_chipselect,
    input  logic                  ctl_write,
    input  logic                  ctl_read,
    input  logic [31:0]           ctl_writedata,
    output logic [31:0]           ctl_readdata,
    output logic                  irq,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    input  logic [DATA_W-1:0]     mem_readdata
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   start_reg;
    logic [CNT_W-1:0]    count_reg;
    logic [DATA_W-1:0]   pattern_reg;
    logic [DATA_W-1:0]   result_reg;
    logic                mode_reg;
    logic                ie_reg;
    logic                incr_reg;
    logic                done_reg;
    logic                aborted_reg;
    logic [CNT_W-1:0]    remaining_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   data_reg;
    logic                cs_reg;
    logic                we_reg;
    logic                acc_valid_reg;
    logic [31:0]         readdata_reg;

    logic ctl_wr;
    logic wr_ctrl;
    logic busy;
    logic go;
    logic abort;

    assign ctl_wr  = ctl_chipselect & ctl_write;
    assign wr_ctrl = ctl_wr && (ctl_address == 3'd3);
    assign busy    = (state_reg != IDLE);
    assign go      = wr_ctrl & ctl_writedata[0] & ~busy;
    assign abort   = wr_ctrl & ctl_writedata[5] & busy;

    assign mem_address    = addr_reg;
    assign mem_byteenable = '1;
    assign mem_chipselect = cs_reg;
    assign mem_write      = we_reg;
    assign mem_writedata  = data_reg;
    assign irq            = done_reg & ie_reg;
    assign ctl_readdata   = readdata_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            start_reg     <= '0;
            count_reg     <= '0;
            pattern_reg   <= '0;
            result_reg    <= '0;
            mode_reg      <= 1'b0;
            ie_reg        <= 1'b0;
            incr_reg      <= 1'b0;
            done_reg      <= 1'b0;
            aborted_reg   <= 1'b0;
            remaining_reg <= '0;
            addr_reg      <= '0;
            data_reg      <= '0;
            cs_reg        <= 1'b0;
            we_reg        <= 1'b0;
            acc_valid_reg <= 1'b0;
        end else begin
            if (ctl_wr && !busy) begin
                case (ctl_address)
                    3'd0:    start_reg   <= ctl_writedata[ADDR_W-1:0];
                    3'd1:    count_reg   <= ctl_writedata[CNT_W-1:0];
                    3'd2:    pattern_reg <= ctl_writedata[DATA_W-1:0];
                    default: ;
                endcase
            end

            if (wr_ctrl) begin
                ie_reg <= ctl_writedata[2];
                if (!busy) begin
                    mode_reg <= ctl_writedata[1];
                    incr_reg <= ctl_writedata[4];
                end
                if (ctl_writedata[3]) begin
                    done_reg    <= 1'b0;
                    aborted_reg <= 1'b0;
                end
            end

            // Memory returns data one cycle after the address, so sums lag issue by one.
            acc_valid_reg <= cs_reg & ~we_reg;
            if (acc_valid_reg)
                result_reg <= result_reg + mem_readdata;

            case (state_reg)
                IDLE: begin
                    if (go) begin
                        done_reg    <= 1'b0;
                        aborted_reg <= 1'b0;
                        result_reg  <= '0;
                        if (count_reg == '0) begin
                            state_reg <= FINISH;
                        end else begin
                            state_reg     <= RUN;
                            cs_reg        <= 1'b1;
                            we_reg        <= ~ctl_writedata[1];
                            addr_reg      <= start_reg;
                            data_reg      <= pattern_reg;
                            remaining_reg <= count_reg;
                        end
                    end
                end
                RUN: begin
                    addr_reg      <= addr_reg + ADDR_W'(1);
                    remaining_reg <= remaining_reg - CNT_W'(1);
                    if (incr_reg)
                        data_reg <= data_reg + DATA_W'(1);
                    if (remaining_reg == CNT_W'(1)) begin
                        cs_reg    <= 1'b0;
                        we_reg    <= 1'b0;
                        state_reg <= mode_reg ? DRAIN : FINISH;
                    end
                end
                DRAIN: begin
                    state_reg <= FINISH;
                end
                FINISH: begin
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase

            // Abort overrides whatever the FSM decided this cycle; an in-flight read still lands.
            if (abort) begin
                state_reg   <= IDLE;
                cs_reg      <= 1'b0;
                we_reg      <= 1'b0;
                aborted_reg <= 1'b1;
                done_reg    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_reg <= '0;
        end else if (ctl_chipselect && ctl_read) begin
            case (ctl_address)
                3'd0:    readdata_reg <= 32'(start_reg);
                3'd1:    readdata_reg <= 32'(count_reg);
                3'd2:    readdata_reg <= 32'(pattern_reg);
                3'd3:    readdata_reg <= {25'd0, aborted_reg, 1'b0, incr_reg,
                                          done_reg, ie_reg, mode_reg, busy};
                3'd4:    readdata_reg <= 32'(result_reg);
                default: readdata_reg <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_nios2_ls_onchip_memory_fill_engine.sv
// Directed bench for the fill/checksum engine with a behavioural 8192x32 RAM behind it.
module tb_nios2_ls_onchip_memory_fill_engine;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  ctl_address = '0;
    logic        ctl_chipselect = 1'b0;
    logic        ctl_write = 1'b0;
    logic        ctl_read = 1'b0;
    logic [31:0] ctl_writedata = '0;
    logic [31:0] ctl_readdata;
    logic        irq;
    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    always #5 clk = ~clk;

    nios2_ls_onchip_memory_fill_engine #(.ADDR_W(13), .DATA_W(32), .CNT_W(14)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ctl_address    (ctl_address),
        .ctl_chipselect (ctl_chipselect),
        .ctl_write      (ctl_write),
        .ctl_read       (ctl_read),
        .ctl_writedata  (ctl_writedata),
        .ctl_readdata   (ctl_readdata),
        .irq            (irq),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (mem_readdata)
    );

    // RAM model: registered address, unregistered data out
    logic [31:0] mem [0:8191];
    logic [12:0] rd_addr = '0;
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) mem[mem_address] <= mem_writedata;
            rd_addr <= mem_address;
        end
    end
    assign mem_readdata = mem[rd_addr];

    int          wr_cnt = 0;
    int          cs_cnt = 0;
    logic [12:0] wr_addr_log [0:255];
    logic [31:0] wr_data_log [0:255];
    always @(posedge clk) begin
        if (reset_n && mem_chipselect) begin
            cs_cnt++;
            if (mem_write) begin
                wr_addr_log[wr_cnt % 256] = mem_address;
                wr_data_log[wr_cnt % 256] = mem_writedata;
                wr_cnt++;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Bus tasks are entered on a negedge and return on the next negedge.
    task automatic ctl_wr(input logic [2:0] a, input logic [31:0] d);
        ctl_address = a; ctl_writedata = d; ctl_chipselect = 1'b1; ctl_write = 1'b1;
        @(negedge clk);
        ctl_chipselect = 1'b0; ctl_write = 1'b0;
    endtask

    task automatic ctl_rd(input logic [2:0] a, output logic [31:0] d);
        ctl_address = a; ctl_chipselect = 1'b1; ctl_read = 1'b1;
        @(negedge clk);
        ctl_chipselect = 1'b0; ctl_read = 1'b0;
        d = ctl_readdata;
    endtask

    task automatic wait_irq(input int max, output int cyc);
        cyc = 1;
        while (!irq && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          c;
        int          base;

        repeat (3) @(negedge clk);
        check_eq("reset_irq", {31'd0, irq}, 32'd0);
        check_eq("reset_cs", {31'd0, mem_chipselect}, 32'd0);
        check_eq("reset_be", {28'd0, mem_byteenable}, 32'h0000000F);
        check_eq("reset_rdata", ctl_readdata, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        ctl_rd(3'd3, rd);
        check_eq("reset_status", rd, 32'd0);

        // Constant fill
        ctl_wr(3'd0, 32'h10);
        ctl_wr(3'd1, 32'd4);
        ctl_wr(3'd2, 32'hA5A5A5A5);
        base = wr_cnt;
        ctl_wr(3'd3, 32'h05);
        wait_irq(40, c);
        check_eq("fill_done_cycle", c, 32'd6);
        check_eq("fill_nwrites", wr_cnt - base, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("fill_addr%0d", i), {19'd0, wr_addr_log[(base + i) % 256]}, 32'h10 + i);
            check_eq($sformatf("fill_data%0d", i), wr_data_log[(base + i) % 256], 32'hA5A5A5A5);
        end
        ctl_rd(3'd3, rd);
        check_eq("fill_status", rd, 32'h0C);

        // Incrementing fill across the address wrap
        ctl_wr(3'd0, 32'h1FFE);
        ctl_wr(3'd1, 32'd4);
        ctl_wr(3'd2, 32'hFFFFFFFF);
        base = wr_cnt;
        ctl_wr(3'd3, 32'h15);
        wait_irq(40, c);
        check_eq("incr_done_cycle", c, 32'd6);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("incr_addr%0d", i), {19'd0, wr_addr_log[(base + i) % 256]}, (32'h1FFE + i) % 32'h2000);
            check_eq($sformatf("incr_data%0d", i), wr_data_log[(base + i) % 256], 32'hFFFFFFFF + i);
        end

        // Preload 1,2,3 then 0xFFFFFFFF at 0x100..0x103 through the engine
        ctl_wr(3'd0, 32'h100);
        ctl_wr(3'd1, 32'd3);
        ctl_wr(3'd2, 32'd1);
        ctl_wr(3'd3, 32'h15);
        wait_irq(40, c);
        ctl_wr(3'd0, 32'h103);
        ctl_wr(3'd1, 32'd1);
        ctl_wr(3'd2, 32'hFFFFFFFF);
        ctl_wr(3'd3, 32'h05);
        wait_irq(40, c);
        check_eq("preload_done_cycle", c, 32'd3);

        // Checksum
        ctl_wr(3'd0, 32'h100);
        ctl_wr(3'd1, 32'd4);
        ctl_wr(3'd3, 32'h07);
        wait_irq(40, c);
        check_eq("sum_done_cycle", c, 32'd7);
        ctl_rd(3'd4, rd);
        check_eq("sum_result", rd, 32'd5);
        ctl_rd(3'd3, rd);
        check_eq("sum_status", rd, 32'h0E);
        ctl_wr(3'd3, 32'h0C);
        check_eq("sum_irq_cleared", {31'd0, irq}, 32'd0);

        // Zero count
        ctl_wr(3'd1, 32'd0);
        base = cs_cnt;
        ctl_wr(3'd3, 32'h05);
        wait_irq(40, c);
        check_eq("zero_done_cycle", c, 32'd2);
        check_eq("zero_no_access", cs_cnt - base, 32'd0);
        ctl_rd(3'd4, rd);
        check_eq("zero_result", rd, 32'd0);

        // Abort on the 10th RUN cycle
        ctl_wr(3'd0, 32'h200);
        ctl_wr(3'd1, 32'd100);
        base = wr_cnt;
        ctl_wr(3'd3, 32'h01);
        repeat (9) @(negedge clk);
        ctl_wr(3'd3, 32'h20);
        check_eq("abort_cs_dropped", {31'd0, mem_chipselect}, 32'd0);
        repeat (3) @(negedge clk);
        check_eq("abort_nwrites", wr_cnt - base, 32'd10);
        check_eq("abort_last_addr", {19'd0, wr_addr_log[(base + 9) % 256]}, 32'h209);
        ctl_rd(3'd3, rd);
        check_eq("abort_status", rd, 32'h40);
        ctl_wr(3'd0, 32'h55);
        ctl_rd(3'd0, rd);
        check_eq("abort_start_wr", rd, 32'h55);

        // Reset in the middle of a checksum
        ctl_wr(3'd0, 32'h0);
        ctl_wr(3'd1, 32'd50);
        ctl_wr(3'd2, 32'h1234);
        ctl_wr(3'd3, 32'h07);
        repeat (3) @(negedge clk);
        check_eq("rst_cs_running", {31'd0, mem_chipselect}, 32'd1);
        #2 reset_n = 1'b0;
        #1 check_eq("rst_cs_async", {31'd0, mem_chipselect}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            ctl_rd(3'(i), rd);
            check_eq($sformatf("rst_reg%0d", i), rd, 32'd0);
        end

        // go and COUNT writes while busy are ignored
        ctl_wr(3'd0, 32'h300);
        ctl_wr(3'd1, 32'd20);
        base = wr_cnt;
        ctl_wr(3'd3, 32'h05);
        ctl_wr(3'd1, 32'd5);
        ctl_wr(3'd3, 32'h05);
        wait_irq(100, c);
        check_eq("busy_go_done_cycle", c, 32'd20);
        check_eq("busy_go_nwrites", wr_cnt - base, 32'd20);
        check_eq("busy_go_last_addr", {19'd0, wr_addr_log[(base + 19) % 256]}, 32'h313);
        ctl_rd(3'd1, rd);
        check_eq("busy_count_kept", rd, 32'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
